// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side signal bundle for the L1 data cache controller.
// The cache uses the slave view; the CPU/memory environment uses the master view.
interface dcache_controller_if;
  logic         p1_req_i;
  logic         p1_MemRead_i;
  logic         p1_MemWrite_i;
  logic [31:0]  p1_addr_i;
  logic [31:0]  p1_data_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_ack_i;
  logic [255:0] mem_data_i;

  modport slave (
    input  p1_req_i, p1_MemRead_i, p1_MemWrite_i, p1_addr_i, p1_data_i,
    input  mem_ack_i, mem_data_i,
    output p1_data_o, p1_stall_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output p1_req_i, p1_MemRead_i, p1_MemWrite_i, p1_addr_i, p1_data_i,
    output mem_ack_i, mem_data_i,
    input  p1_data_o, p1_stall_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Hits are serviced combinationally; misses stall while lines are written back and refilled.
module dcache_controller #(
  parameter int INDEX_BITS = 5,
  parameter int TAG_BITS   = 22,
  parameter int LINE_BITS  = 256
) (
  input logic                clk_i,
  input logic                rst_i,
  dcache_controller_if.slave bus
);

  localparam int LINES       = 1 << INDEX_BITS;
  localparam int OFFSET_BITS = 32 - TAG_BITS - INDEX_BITS;
  localparam int WORD_BITS   = OFFSET_BITS - 2;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WRITEBACK = 2'd1;
  localparam logic [1:0] S_ALLOCATE  = 2'd2;
  localparam logic [1:0] S_REFILLED  = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [LINES-1:0]      r_valid;
  logic [LINES-1:0]      r_dirty;
  logic [TAG_BITS-1:0]   r_tag  [LINES];
  logic [LINE_BITS-1:0]  r_data [LINES];
  logic [TAG_BITS-1:0]   r_miss_tag;
  logic [INDEX_BITS-1:0] r_miss_idx;
  logic                  r_mem_enable;
  logic                  r_mem_write;
  logic [31:0]           r_mem_addr;
  logic [LINE_BITS-1:0]  r_mem_data;

  logic [TAG_BITS-1:0]   w_tag;
  logic [INDEX_BITS-1:0] w_idx;
  logic [WORD_BITS-1:0]  w_word;
  logic [LINE_BITS-1:0]  w_line;
  logic [31:0]           w_rd_word;
  logic                  w_hit;
  logic                  w_idle;
  logic                  w_load;
  logic                  w_wr_hit;
  logic                  w_miss_start;
  logic                  w_victim_dirty;
  logic                  w_wb_done;
  logic                  w_fill_done;
  logic                  w_unused;

  assign w_tag  = bus.p1_addr_i[31 -: TAG_BITS];
  assign w_idx  = bus.p1_addr_i[OFFSET_BITS +: INDEX_BITS];
  assign w_word = bus.p1_addr_i[2 +: WORD_BITS];
  assign w_unused = &{1'b0, bus.p1_addr_i[1:0]};

  assign w_line    = r_data[w_idx];
  assign w_rd_word = w_line[{w_word, 5'd0} +: 32];

  assign w_hit  = bus.p1_req_i & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_idle = (r_state == S_IDLE);
  // A simultaneous read and write is treated as a store.
  assign w_load         = bus.p1_MemRead_i & ~bus.p1_MemWrite_i;
  assign w_wr_hit       = w_idle & w_hit & bus.p1_MemWrite_i;
  assign w_miss_start   = w_idle & bus.p1_req_i & ~w_hit;
  assign w_victim_dirty = r_valid[w_idx] & r_dirty[w_idx];
  assign w_wb_done      = (r_state == S_WRITEBACK) & bus.mem_ack_i;
  assign w_fill_done    = (r_state == S_ALLOCATE) & bus.mem_ack_i;

  assign bus.p1_stall_o   = (bus.p1_req_i & ~w_hit) | ~w_idle;
  assign bus.p1_data_o    = (w_hit & w_load) ? w_rd_word : 32'd0;
  assign bus.mem_enable_o = r_mem_enable;
  assign bus.mem_write_o  = r_mem_write;
  assign bus.mem_addr_o   = r_mem_addr;
  assign bus.mem_data_o   = r_mem_data;

  // Next-state selection for the miss-handling FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_miss_start) begin
          w_state_nxt = w_victim_dirty ? S_WRITEBACK : S_ALLOCATE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WRITEBACK: begin
        if (bus.mem_ack_i) begin
          w_state_nxt = S_ALLOCATE;
        end else begin
          w_state_nxt = S_WRITEBACK;
        end
      end
      S_ALLOCATE: begin
        if (bus.mem_ack_i) begin
          w_state_nxt = S_REFILLED;
        end else begin
          w_state_nxt = S_ALLOCATE;
        end
      end
      S_REFILLED: w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state, line status bits and the registered memory request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= S_IDLE;
      r_valid      <= {LINES{1'b0}};
      r_dirty      <= {LINES{1'b0}};
      r_miss_tag   <= {TAG_BITS{1'b0}};
      r_miss_idx   <= {INDEX_BITS{1'b0}};
      r_mem_enable <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_data   <= {LINE_BITS{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if (w_wr_hit) begin
        r_dirty[w_idx] <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_miss_start) begin
            // Remember the missing line so a withdrawn request still completes cleanly.
            r_miss_tag   <= w_tag;
            r_miss_idx   <= w_idx;
            r_mem_enable <= 1'b1;
            if (w_victim_dirty) begin
              r_mem_write <= 1'b1;
              r_mem_addr  <= {r_tag[w_idx], w_idx, {OFFSET_BITS{1'b0}}};
              r_mem_data  <= w_line;
            end else begin
              r_mem_write <= 1'b0;
              r_mem_addr  <= {w_tag, w_idx, {OFFSET_BITS{1'b0}}};
            end
          end
        end
        S_WRITEBACK: begin
          if (w_wb_done) begin
            // Enable stays high: the read is issued straight after the write-back.
            r_dirty[r_miss_idx] <= 1'b0;
            r_mem_write         <= 1'b0;
            r_mem_addr          <= {r_miss_tag, r_miss_idx, {OFFSET_BITS{1'b0}}};
          end
        end
        S_ALLOCATE: begin
          if (w_fill_done) begin
            r_valid[r_miss_idx] <= 1'b1;
            r_dirty[r_miss_idx] <= 1'b0;
            r_mem_enable        <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Tag and data arrays: refill installs a full line, a store hit patches one word.
  always_ff @(posedge clk_i) begin
    if (w_fill_done) begin
      r_data[r_miss_idx] <= bus.mem_data_i;
      r_tag[r_miss_idx]  <= r_miss_tag;
    end else if (w_wr_hit) begin
      r_data[w_idx][{w_word, 5'd0} +: 32] <= bus.p1_data_i;
    end
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache controller between the CPU MEM stage and the 256-bit line-based data memory.
- Acts as the initiator of the memory's enable/write/ack handshake.
- Serves 32-bit CPU loads and stores: hits complete with zero added latency; misses stall the CPU while lines are written back and refilled.

Parameters:
- INDEX_BITS, 5, line index width (32 lines).
- TAG_BITS, 22, tag width (addr[31:10]).
- LINE_BITS, 256, line width (32 bytes, 8 words).

Ports:
- clk_i  input  1  clock; all state updates on its rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- p1_req_i  input  1  CPU access valid (MemRead or MemWrite).
- p1_MemRead_i  input  1  load request.
- p1_MemWrite_i  input  1  store request.
- p1_addr_i  input  32  byte address; [1:0] ignored.
- p1_data_i  input  32  store data.
- p1_data_o  output  32  load data; valid when p1_stall_o=0.
- p1_stall_o  output  1  CPU must hold the request stable and freeze.
- mem_enable_o  output  1  memory request; held until ack.
- mem_write_o  output  1  1 = line write-back, 0 = line read.
- mem_addr_o  output  32  line address, [4:0]=0.
- mem_data_o  output  256  write-back line.
- mem_ack_i  input  1  one-cycle completion pulse from memory.
- mem_data_i  input  256  refill line; valid in the ack cycle.

Behaviour:
- Address split: tag=addr[31:10], index=addr[9:5], word=addr[4:2].
- Per-line storage: valid, dirty, tag, 256-bit data.
- Reset: all valid and dirty cleared, state=IDLE, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, p1_data_o=0. Data/tag arrays are not cleared.
- hit = p1_req_i & valid[index] & (tag[index]==addr tag); combinational.
- p1_stall_o = p1_req_i & ~hit, or state != IDLE. Combinational.
- Read hit: p1_data_o = word[word] of the indexed line, same cycle; no state change.
- Write hit: on the clock edge, the selected 32-bit word is replaced with p1_data_i and dirty[index] is set.
- FSM states: IDLE, WRITEBACK, ALLOCATE, REFILLED.
- IDLE, on a miss:
  - valid & dirty → WRITEBACK. Drive enable=1, write=1, addr={old tag, index, 5'b0}, data=old line.
  - Otherwise → ALLOCATE. Drive enable=1, write=0, addr={req tag, index, 5'b0}.
- WRITEBACK:
  - enable/write/addr/data held constant until mem_ack_i.
  - On the ack edge: dirty[index] cleared, then ALLOCATE is issued with enable=1, write=0, addr=new line.
  - Enable stays high across this transition; the memory's post-ack idle cycle absorbs it.
- ALLOCATE:
  - Held until mem_ack_i.
  - On the ack edge: line=mem_data_i, tag=req tag, valid=1, dirty=0, enable=0 → REFILLED.
- REFILLED: one cycle, stall stays 1, then → IDLE. The request now hits and is serviced like any hit (a store sets dirty then).
- mem_enable_o is registered and drops on the same edge that samples mem_ack_i. No request is issued while p1_req_i=0.
- mem_ack_i outside WRITEBACK/ALLOCATE is ignored.
- Memory latency is unbounded: the FSM waits indefinitely (nominal 10+ cycles).
- Request withdrawn mid-miss (p1_req_i drops): the current memory transaction still completes and the line is installed; no CPU side effect.
- Reset mid-operation: immediate abort to IDLE, enable dropped, all lines invalid.
- p1_MemRead_i and p1_MemWrite_i both high is illegal; the store takes priority.

Test Plan:
- Cold load 0x0000_0404 after reset → stall=1, one read (enable=1, write=0, addr=0x400) held until ack. Install, REFILLED, then hit returns word 1 of the memory line, stall=0.
- Store 0xDEADBEEF to 0x404, then load 0x404 → both hits, zero stall cycles. Load returns 0xDEADBEEF; dirty[0]=1.
- Load 0x0000_0804 (same index, new tag) after the dirty store → write-back at addr 0x400 with the updated line containing 0xDEADBEEF, then read at 0x800. Enable stays high across the back-to-back transactions; memory[0x400>>5] is updated.
- Conflict miss on a clean line → no write-back; exactly one read transaction issued.
- Assert rst_i=0 during WRITEBACK wait → outputs return to reset values asynchronously. Subsequent access to the same address misses.
- Extended ack latency (ack after 30 cycles) → address, data, enable and write stay stable throughout; exactly one transaction per ack.
